alu8_sched: RTL and testbench
=============================

// Module: alu8_sched
// PURPOSE
//  Shares one combinational ALU_8 (opcode[3:0], a/b[7:0] -> res[8:0], carry, zero) between two
//  requesters. Round-robin arbitration, operand latching, a programmable settle window and a
//  registered response channel with valid/ready back-pressure. Sits between the two issuing
//  units and the single ALU_8 instance, which is instantiated at the parent level.
// PARAMETERS
//  WIDTH        8   operand width; result width is WIDTH+1
//  OPW          4   opcode width
//  EXEC_CYCLES  1   cycles alu_* are held stable before the result is captured (1..15)
// PORTS
//  clk          in   1        system clock, rising edge
//  rst          in   1        asynchronous reset, active-high
//  r0_valid     in   1        requester 0 has an operation
//  r0_ready     out  1        requester 0 operation accepted this cycle
//  r0_opcode    in   OPW      requester 0 opcode
//  r0_a, r0_b   in   WIDTH    requester 0 operands
//  r1_valid/r1_ready/r1_opcode/r1_a/r1_b   same as r0_*, requester 1
//  alu_opcode   out  OPW      to ALU_8 opcode
//  alu_a, alu_b out  WIDTH    to ALU_8 operands
//  alu_res      in   WIDTH+1  from ALU_8 res
//  alu_carry    in   1        from ALU_8 carry
//  alu_zero     in   1        from ALU_8 zero
//  rsp_valid    out  1        response available
//  rsp_ready    in   1        consumer accepts response
//  rsp_id       out  1        requester the response belongs to
//  rsp_res      out  WIDTH+1  captured result
//  rsp_carry    out  1        captured carry
//  rsp_zero     out  1        captured zero
//  busy         out  1        high in EXEC or RESP
// BEHAVIOUR
//  - Reset (async, rst=1): state=IDLE, last_grant=1 (so r0 wins the first tie). All registered
//    outputs are 0: alu_opcode, alu_a, alu_b, rsp_*, busy.
//  - FSM IDLE -> EXEC -> RESP -> IDLE.
//  - IDLE: rN_ready = (state==IDLE) && grant==N, driven combinationally from the valids.
//    grant: one valid wins; both valid -> the requester that is not last_grant wins. On
//    accept, opcode/a/b are latched onto alu_*, rsp_id<=grant, cnt<=EXEC_CYCLES-1, go EXEC.
//    At most one ready is high per cycle. No valid -> stay in IDLE.
//  - EXEC: alu_* are held constant. cnt decrements each cycle. At cnt==0, alu_res, alu_carry
//    and alu_zero are captured into rsp_*, go RESP.
//  - RESP: rsp_valid=1. rsp_* and alu_* stay stable until rsp_ready. On rsp_valid&&rsp_ready,
//    last_grant<=rsp_id, rsp_valid drops next cycle, go IDLE. No new request is accepted in
//    the cycle the response is taken.
//  - Latency from accept to rsp_valid is EXEC_CYCLES+1 cycles. Minimum issue interval is
//    EXEC_CYCLES+2 cycles.
//  - Widths: res is passed through unchanged at WIDTH+1 bits; the block does no arithmetic
//    on data.
//  - Back-pressure: rsp_ready held low keeps the block in RESP indefinitely. Both rN_ready
//    stay 0 meanwhile.
//  - rsp_ready while rsp_valid=0 is ignored.
//  - Reset mid-EXEC or mid-RESP abandons the operation. No response is produced, and
//    last_grant returns to 1.
// STRUCTURE
//  - Package alu8_pkg: WIDTH/OPW defaults, state encoding (ST_IDLE=2'd0, ST_EXEC=2'd1,
//    ST_RESP=2'd2), requester ids REQ0=1'b0 and REQ1=1'b1.
//  - One sub-module, rr_arb2: 2-way round-robin grant from (v0, v1, last_grant) ->
//    (gnt_valid, gnt_id). It is combinational; last_grant is held in alu8_sched.
//  - The FSM, counter and operand/response registers live in alu8_sched.
// TESTING (bench drives alu_* inputs from a behavioural ALU_8 stub, EXEC_CYCLES=1 unless noted)
//  1 Reset: assert rst mid-run -> all outputs 0 immediately, state IDLE, busy=0.
//  2 Single op: r0 valid, opcode=0, a=8'h14, b=8'h4F; stub res=9'h063 -> r0_ready for 1 cycle;
//    rsp_valid 2 cycles later with rsp_id=0, rsp_res=9'h063, carry=0, zero=0.
//  3 Contention: r0 and r1 valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1, with
//    a new grant every 3 cycles and never both readys high.
//  4 Back-pressure: hold rsp_ready=0 for 10 cycles in RESP -> rsp_* stable, r0_ready=r1_ready=0;
//    release -> one handshake, then IDLE.
//  5 Settle window: EXEC_CYCLES=4; stub changes alu_res 2 cycles after accept -> rsp_res
//    equals the value present at cycle 4. Also a=8'hFF, b=8'h01 add with stub res=9'h100,
//    carry=1, zero=1 -> passed through exactly.
//  6 Reset in EXEC: rst pulse 1 cycle after accept -> no rsp_valid follows; next tie grants r0.

Source files
------------

// File: rtl/alu8_pkg.sv
// Shared definitions for the two-requester ALU_8 scheduler.
// Holds the default data/opcode widths, the scheduler state encoding and
// the requester identifiers used on rsp_id and by the round-robin arbiter.
package alu8_pkg;

    localparam int DEF_WIDTH = 8;   // operand width; results are DEF_WIDTH+1 bits
    localparam int DEF_OPW   = 4;   // opcode width

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant, purely combinational.
// Ports:
//   v0, v1      in   request valids from requester 0 / 1
//   last_grant  in   id of the requester served most recently
//   gnt_valid   out  at least one requester is asking
//   gnt_id      out  id of the winning requester (meaningful when gnt_valid)
// The last_grant state lives in the caller so it only advances when a
// response is actually handed over.
module rr_arb2
    import alu8_pkg::*;
(
    input  logic v0,
    input  logic v1,
    input  logic last_grant,
    output logic gnt_valid,
    output logic gnt_id
);

    always_comb begin
        gnt_valid = v0 | v1;
        if (v0 && v1) begin
            // Tie: serve whoever was not served last time.
            gnt_id = ~last_grant;
        end else if (v1) begin
            gnt_id = REQ1;
        end else begin
            gnt_id = REQ0;
        end
    end

endmodule

// File: rtl/alu8_sched.sv
// Time-shares one external combinational ALU_8 between two requesters.
// An accepted operation is latched onto alu_*, held for EXEC_CYCLES cycles so
// the ALU output can settle, then the ALU result is captured into a response
// register presented with valid/ready handshaking.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   rN_valid/rN_ready             request handshake for requester N (0/1)
//   rN_opcode, rN_a, rN_b         request payload for requester N
//   alu_opcode, alu_a, alu_b      registered drive into the shared ALU_8
//   alu_res, alu_carry, alu_zero  ALU_8 outputs, sampled at end of EXEC
//   rsp_valid/rsp_ready           response handshake
//   rsp_id, rsp_res, rsp_carry, rsp_zero  captured response payload
//   busy                          an operation is in flight (EXEC or RESP)
module alu8_sched #(
    parameter int WIDTH       = alu8_pkg::DEF_WIDTH,
    parameter int OPW         = alu8_pkg::DEF_OPW,
    parameter int EXEC_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             r0_valid,
    output logic             r0_ready,
    input  logic [OPW-1:0]   r0_opcode,
    input  logic [WIDTH-1:0] r0_a,
    input  logic [WIDTH-1:0] r0_b,
    input  logic             r1_valid,
    output logic             r1_ready,
    input  logic [OPW-1:0]   r1_opcode,
    input  logic [WIDTH-1:0] r1_a,
    input  logic [WIDTH-1:0] r1_b,
    output logic [OPW-1:0]   alu_opcode,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH:0]   alu_res,
    input  logic             alu_carry,
    input  logic             alu_zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH:0]   rsp_res,
    output logic             rsp_carry,
    output logic             rsp_zero,
    output logic             busy
);

    import alu8_pkg::*;

    localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

    state_t           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [OPW-1:0]   alu_opcode_q, alu_opcode_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_id_q, rsp_id_d;
    logic [WIDTH:0]   rsp_res_q, rsp_res_d;
    logic             rsp_carry_q, rsp_carry_d;
    logic             rsp_zero_q, rsp_zero_d;
    logic             busy_q, busy_d;

    logic gnt_valid;
    logic gnt_id;

    rr_arb2 u_arb (
        .v0         (r0_valid),
        .v1         (r1_valid),
        .last_grant (last_grant_q),
        .gnt_valid  (gnt_valid),
        .gnt_id     (gnt_id)
    );

    // Readys only in IDLE, so nothing is taken while a response is pending
    // or in the cycle it is consumed.
    assign r0_ready = (state_q == ST_IDLE) && gnt_valid && (gnt_id == REQ0);
    assign r1_ready = (state_q == ST_IDLE) && gnt_valid && (gnt_id == REQ1);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        alu_opcode_d = alu_opcode_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_res_d    = rsp_res_q;
        rsp_carry_d  = rsp_carry_q;
        rsp_zero_d   = rsp_zero_q;
        busy_d       = busy_q;

        case (state_q)
            ST_IDLE: begin
                if (gnt_valid) begin
                    alu_opcode_d = (gnt_id == REQ1) ? r1_opcode : r0_opcode;
                    alu_a_d      = (gnt_id == REQ1) ? r1_a      : r0_a;
                    alu_b_d      = (gnt_id == REQ1) ? r1_b      : r0_b;
                    rsp_id_d     = gnt_id;
                    cnt_d        = CNT_INIT;
                    busy_d       = 1'b1;
                    state_d      = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (cnt_q == 4'd0) begin
                    rsp_res_d   = alu_res;
                    rsp_carry_d = alu_carry;
                    rsp_zero_d  = alu_zero;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                // Arbitration history only advances once the response is taken.
                if (rsp_ready) begin
                    last_grant_d = rsp_id_q;
                    rsp_valid_d  = 1'b0;
                    busy_d       = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= REQ1;   // requester 0 wins the first tie
            cnt_q        <= 4'd0;
            alu_opcode_q <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_res_q    <= '0;
            rsp_carry_q  <= 1'b0;
            rsp_zero_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            alu_opcode_q <= alu_opcode_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_res_q    <= rsp_res_d;
            rsp_carry_q  <= rsp_carry_d;
            rsp_zero_q   <= rsp_zero_d;
            busy_q       <= busy_d;
        end
    end

    assign alu_opcode = alu_opcode_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_res    = rsp_res_q;
    assign rsp_carry  = rsp_carry_q;
    assign rsp_zero   = rsp_zero_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_alu8_sched.sv
// Directed bench for alu8_sched: one instance with EXEC_CYCLES=1 and one with
// EXEC_CYCLES=4, each driven by a behavioural ALU_8 stub.
module tb_alu8_sched;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // EXEC_CYCLES=1 instance
    logic       r0_valid, r0_ready, r1_valid, r1_ready;
    logic [3:0] r0_opcode, r1_opcode, alu_opcode;
    logic [7:0] r0_a, r0_b, r1_a, r1_b, alu_a, alu_b;
    logic [8:0] alu_res, rsp_res;
    logic       alu_carry, alu_zero;
    logic       rsp_valid, rsp_ready, rsp_id, rsp_carry, rsp_zero, busy;

    // EXEC_CYCLES=4 instance
    logic       q_r0_valid, q_r0_ready, q_r1_valid, q_r1_ready;
    logic [3:0] q_r0_opcode, q_r1_opcode, q_alu_opcode;
    logic [7:0] q_r0_a, q_r0_b, q_r1_a, q_r1_b, q_alu_a, q_alu_b;
    logic [8:0] q_alu_res, q_rsp_res;
    logic       q_alu_carry, q_alu_zero;
    logic       q_rsp_valid, q_rsp_ready, q_rsp_id, q_rsp_carry, q_rsp_zero, q_busy;
    logic       q_ovr_en;
    logic [8:0] q_ovr_res;

    alu8_sched dut (
        .clk(clk), .rst(rst),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_opcode(r0_opcode), .r0_a(r0_a), .r0_b(r0_b),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_opcode(r1_opcode), .r1_a(r1_a), .r1_b(r1_b),
        .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
        .alu_res(alu_res), .alu_carry(alu_carry), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_res(rsp_res),
        .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .busy(busy)
    );

    alu8_sched #(.EXEC_CYCLES(4)) dut4 (
        .clk(clk), .rst(rst),
        .r0_valid(q_r0_valid), .r0_ready(q_r0_ready), .r0_opcode(q_r0_opcode), .r0_a(q_r0_a), .r0_b(q_r0_b),
        .r1_valid(q_r1_valid), .r1_ready(q_r1_ready), .r1_opcode(q_r1_opcode), .r1_a(q_r1_a), .r1_b(q_r1_b),
        .alu_opcode(q_alu_opcode), .alu_a(q_alu_a), .alu_b(q_alu_b),
        .alu_res(q_alu_res), .alu_carry(q_alu_carry), .alu_zero(q_alu_zero),
        .rsp_valid(q_rsp_valid), .rsp_ready(q_rsp_ready), .rsp_id(q_rsp_id), .rsp_res(q_rsp_res),
        .rsp_carry(q_rsp_carry), .rsp_zero(q_rsp_zero), .busy(q_busy)
    );

    // Behavioural ALU_8 stub: 0 add, 1 sub, 2 and, 3 or, others xor.
    function automatic logic [8:0] alu_stub(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            4'd0:    alu_stub = {1'b0, a} + {1'b0, b};
            4'd1:    alu_stub = {1'b0, a} - {1'b0, b};
            4'd2:    alu_stub = {1'b0, a & b};
            4'd3:    alu_stub = {1'b0, a | b};
            default: alu_stub = {1'b0, a ^ b};
        endcase
    endfunction

    always_comb begin
        alu_res   = alu_stub(alu_opcode, alu_a, alu_b);
        alu_carry = alu_res[8];
        alu_zero  = (alu_res[7:0] == 8'd0);
        q_alu_res   = q_ovr_en ? q_ovr_res : alu_stub(q_alu_opcode, q_alu_a, q_alu_b);
        q_alu_carry = q_alu_res[8];
        q_alu_zero  = (q_alu_res[7:0] == 8'd0);
    end

    // One line per completed response handshake.
    always @(negedge clk) begin
        if (rsp_valid && rsp_ready)
            $display("txn dut  id=%0d res=%03h carry=%0d zero=%0d", rsp_id, rsp_res, rsp_carry, rsp_zero);
        if (q_rsp_valid && q_rsp_ready)
            $display("txn dut4 id=%0d res=%03h carry=%0d zero=%0d", q_rsp_id, q_rsp_res, q_rsp_carry, q_rsp_zero);
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        r0_valid = 0; r0_opcode = 0; r0_a = 0; r0_b = 0;
        r1_valid = 0; r1_opcode = 0; r1_a = 0; r1_b = 0;
        rsp_ready = 0;
        q_r0_valid = 0; q_r0_opcode = 0; q_r0_a = 0; q_r0_b = 0;
        q_r1_valid = 0; q_r1_opcode = 0; q_r1_a = 0; q_r1_b = 0;
        q_rsp_ready = 0; q_ovr_en = 0; q_ovr_res = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_opcode", alu_opcode, 0);
        chk("rst_rsp_res", rsp_res, 0);
        rst = 1'b0;
        #1;

        // Single op from r0: 0x14 + 0x4F = 0x063
        r0_valid = 1; r0_opcode = 4'd0; r0_a = 8'h14; r0_b = 8'h4F;
        #1;
        chk("single_r0_ready", r0_ready, 1);
        chk("single_r1_ready", r1_ready, 0);
        tick();
        r0_valid = 0;
        #1;
        chk("single_ready_drop", r0_ready, 0);
        chk("single_busy", busy, 1);
        chk("single_alu_a", alu_a, 8'h14);
        chk("single_alu_b", alu_b, 8'h4F);
        chk("single_no_rsp_yet", rsp_valid, 0);
        tick();
        chk("single_rsp_valid", rsp_valid, 1);
        chk("single_rsp_id", rsp_id, 0);
        chk("single_rsp_res", rsp_res, 9'h063);
        chk("single_rsp_carry", rsp_carry, 0);
        chk("single_rsp_zero", rsp_zero, 0);

        // Back-pressure: hold in RESP 10 cycles with both requesters asking
        r0_valid = 1; r1_valid = 1;
        r1_opcode = 4'd2; r1_a = 8'hF0; r1_b = 8'h3C;
        #1;
        for (int i = 0; i < 10; i++) begin
            chk("bp_rsp_valid", rsp_valid, 1);
            chk("bp_rsp_res", rsp_res, 9'h063);
            chk("bp_alu_a", alu_a, 8'h14);
            chk("bp_r0_ready", r0_ready, 0);
            chk("bp_r1_ready", r1_ready, 0);
            tick();
        end
        rsp_ready = 1;
        #1;
        chk("bp_take_r0_ready", r0_ready, 0);
        chk("bp_take_r1_ready", r1_ready, 0);
        tick();
        chk("bp_after_rsp_valid", rsp_valid, 0);
        chk("bp_after_busy", busy, 0);
        // r0 was served last, so r1 wins this tie
        chk("rr_r1_ready", r1_ready, 1);
        chk("rr_r0_ready", r0_ready, 0);
        tick();
        r0_valid = 0; r1_valid = 0; rsp_ready = 0;
        tick();
        chk("and_rsp_valid", rsp_valid, 1);
        chk("and_rsp_id", rsp_id, 1);
        chk("and_rsp_res", rsp_res, 9'h030);

        // Asynchronous reset mid-RESP: outputs clear without a clock edge
        rst = 1'b1;
        #1;
        chk("arst_rsp_valid", rsp_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_rsp_id", rsp_id, 0);
        chk("arst_rsp_res", rsp_res, 0);
        chk("arst_alu_a", alu_a, 0);
        chk("arst_alu_opcode", alu_opcode, 4'd2 & 4'd0);
        tick();
        rst = 1'b0;
        #1;

        // Contention: r0 sub 0x50-0x20=0x030, r1 or 0x0F|0xA0=0x0AF
        r0_opcode = 4'd1; r0_a = 8'h50; r0_b = 8'h20;
        r1_opcode = 4'd3; r1_a = 8'h0F; r1_b = 8'hA0;
        r0_valid = 1; r1_valid = 1; rsp_ready = 1;
        #1;
        for (int c = 0; c < 12; c++) begin
            logic g;
            logic id;
            g  = (c % 3 == 0);
            id = ((c / 3) % 2) == 1;
            chk("cont_both_ready", r0_ready & r1_ready, 0);
            chk("cont_r0_ready", r0_ready, g && !id);
            chk("cont_r1_ready", r1_ready, g && id);
            if (c % 3 == 2) begin
                chk("cont_rsp_valid", rsp_valid, 1);
                chk("cont_rsp_id", rsp_id, id);
                chk("cont_rsp_res", rsp_res, id ? 9'h0AF : 9'h030);
            end else begin
                chk("cont_rsp_idle", rsp_valid, 0);
            end
            tick();
        end
        r0_valid = 0; r1_valid = 0;
        #1;
        chk("cont_end_busy", busy, 0);

        // Reset in EXEC: first make r0 the last served
        r0_valid = 1;
        #1;
        chk("rexec_r0_ready", r0_ready, 1);
        tick();
        r0_valid = 0;
        tick();
        chk("rexec_r0_rsp_id", rsp_id, 0);
        tick();
        r1_valid = 1;
        #1;
        chk("rexec_r1_ready", r1_ready, 1);
        tick();
        r1_valid = 0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("rexec_no_rsp", rsp_valid, 0);
            tick();
        end
        r0_valid = 1; r1_valid = 1;
        #1;
        chk("rexec_tie_r0", r0_ready, 1);
        chk("rexec_tie_r1", r1_ready, 0);
        r0_valid = 0; r1_valid = 0;
        tick();

        // Settle window, EXEC_CYCLES=4: value changes two cycles after accept
        q_r0_valid = 1; q_r0_opcode = 4'd0; q_r0_a = 8'h10; q_r0_b = 8'h20;
        #1;
        chk("settle_ready", q_r0_ready, 1);
        tick();
        q_r0_valid = 0;
        chk("settle_busy", q_busy, 1);
        chk("settle_t1", q_rsp_valid, 0);
        tick();
        q_ovr_res = 9'h0AB; q_ovr_en = 1;
        chk("settle_t2", q_rsp_valid, 0);
        tick();
        chk("settle_t3", q_rsp_valid, 0);
        tick();
        chk("settle_t4", q_rsp_valid, 0);
        tick();
        chk("settle_rsp_valid", q_rsp_valid, 1);
        chk("settle_rsp_res", q_rsp_res, 9'h0AB);
        chk("settle_rsp_id", q_rsp_id, 0);
        q_rsp_ready = 1;
        tick();
        q_ovr_en = 0; q_rsp_ready = 0;
        #1;
        chk("settle_done", q_rsp_valid, 0);

        // Carry/zero pass-through: 0xFF + 0x01 = 0x100
        q_r0_valid = 1; q_r0_opcode = 4'd0; q_r0_a = 8'hFF; q_r0_b = 8'h01;
        #1;
        chk("wrap_ready", q_r0_ready, 1);
        tick();
        q_r0_valid = 0;
        repeat (3) tick();
        chk("wrap_t4", q_rsp_valid, 0);
        tick();
        chk("wrap_rsp_valid", q_rsp_valid, 1);
        chk("wrap_rsp_res", q_rsp_res, 9'h100);
        chk("wrap_rsp_carry", q_rsp_carry, 1);
        chk("wrap_rsp_zero", q_rsp_zero, 1);
        q_rsp_ready = 1;
        tick();
        q_rsp_ready = 0;
        #1;
        chk("wrap_busy_done", q_busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
